// File: rtl/processor_state_unit.sv
// ---------------------------------------------------------------------------
// processor_state_unit
//
// SPARC-style processor state: PSR, WIM and TBR, plus a small trap sequencer.
// There are 4 register windows, so CWP arithmetic wraps modulo 4.
//
// Ports
//   Clk, Reset_N            rising-edge clock, asynchronous active-low reset
//   Condition_N/Z/V/C       ALU flags, loaded into icc by Cc_Write
//   Cc_Write                latch ALU flags into PSR icc
//   Psr_Write/Wim_Write/Tbr_Write, Write_Data   WRPSR / WRWIM / WRTBR
//   Save, Restore           register window SAVE / RESTORE requests
//   Trap_Req, Trap_Type     external trap request and its tt value
//   Cond                    Bicc condition field
//   PSR, WIM, TBR           architectural registers (unimplemented bits read 0)
//   Carry_Out               PSR icc C
//   Branch_Taken            Cond evaluated against the current icc
//   Busy                    trap sequence (or error state) in progress
//   Trap_Valid, Trap_Vector one-cycle trap pulse with the target address
//   Error_Mode              trap taken while ET=0; held until reset
// ---------------------------------------------------------------------------
module processor_state_unit (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        Condition_N,
  input  logic        Condition_Z,
  input  logic        Condition_V,
  input  logic        Condition_C,
  input  logic        Cc_Write,
  input  logic        Psr_Write,
  input  logic        Wim_Write,
  input  logic        Tbr_Write,
  input  logic [31:0] Write_Data,
  input  logic        Save,
  input  logic        Restore,
  input  logic        Trap_Req,
  input  logic [7:0]  Trap_Type,
  input  logic [3:0]  Cond,
  output logic [31:0] PSR,
  output logic [31:0] WIM,
  output logic [31:0] TBR,
  output logic        Carry_Out,
  output logic        Branch_Taken,
  output logic        Busy,
  output logic        Trap_Valid,
  output logic [31:0] Trap_Vector,
  output logic        Error_Mode
);

  typedef enum logic [2:0] {
    IDLE,
    TRAP_TBR,
    TRAP_PSR,
    VECTOR,
    ERROR
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        icc_n;
  logic        icc_z;
  logic        icc_v;
  logic        icc_c;
  logic        psr_s;
  logic        psr_ps;
  logic        psr_et;
  logic [1:0]  cwp;
  logic [3:0]  wim_bits;
  logic [19:0] tba;
  logic [7:0]  tt;
  logic [7:0]  pending_tt;

  logic [1:0]  cwp_dec;
  logic [1:0]  cwp_inc;
  logic        in_idle;
  logic        trap_start;
  logic [7:0]  start_tt;
  logic        do_save;
  logic        do_restore;
  logic        do_psr;
  logic        do_cc;
  logic        base_taken;

  // Write_Data bits with no PSR/WIM/TBR field behind them.
  logic        unused_write_bits;
  assign unused_write_bits = ^{Write_Data[11:8], Write_Data[4]};

  // Two-bit window pointer wraps naturally, giving the modulo-4 arithmetic.
  assign cwp_dec = cwp - 2'd1;
  assign cwp_inc = cwp + 2'd1;
  assign in_idle = (state == IDLE);

  // Request arbitration: only one of trap / save / restore / psr / cc acts
  // per cycle, highest priority first. A SAVE or RESTORE that hits an
  // invalid window turns into a window overflow/underflow trap instead.
  always_comb begin
    trap_start = 1'b0;
    start_tt   = 8'h00;
    do_save    = 1'b0;
    do_restore = 1'b0;
    do_psr     = 1'b0;
    do_cc      = 1'b0;
    if (in_idle) begin
      if (Trap_Req) begin
        trap_start = 1'b1;
        start_tt   = Trap_Type;
      end else if (Save) begin
        if (wim_bits[cwp_dec]) begin
          trap_start = 1'b1;
          start_tt   = 8'h05;
        end else begin
          do_save = 1'b1;
        end
      end else if (Restore) begin
        if (wim_bits[cwp_inc]) begin
          trap_start = 1'b1;
          start_tt   = 8'h06;
        end else begin
          do_restore = 1'b1;
        end
      end else if (Psr_Write) begin
        do_psr = 1'b1;
      end else if (Cc_Write) begin
        do_cc = 1'b1;
      end
    end
  end

  // Trap sequencer state register.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A trap with traps disabled parks the unit in ERROR
  // until reset.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (trap_start) begin
          next_state = psr_et ? TRAP_TBR : ERROR;
        end
      end
      TRAP_TBR: next_state = TRAP_PSR;
      TRAP_PSR: next_state = VECTOR;
      VECTOR:   next_state = IDLE;
      ERROR:    next_state = ERROR;
      default:  next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the sequencer state.
  always_comb begin
    Busy        = (state != IDLE);
    Trap_Valid  = (state == VECTOR);
    Error_Mode  = (state == ERROR);
    Trap_Vector = (state == VECTOR) ? TBR : 32'h0000_0000;
  end

  // Integer condition codes. WRPSR beats a same-cycle Cc_Write through the
  // arbitration above.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      icc_n <= 1'b0;
      icc_z <= 1'b0;
      icc_v <= 1'b0;
      icc_c <= 1'b0;
    end else if (do_psr) begin
      icc_n <= Write_Data[23];
      icc_z <= Write_Data[22];
      icc_v <= Write_Data[21];
      icc_c <= Write_Data[20];
    end else if (do_cc) begin
      icc_n <= Condition_N;
      icc_z <= Condition_Z;
      icc_v <= Condition_V;
      icc_c <= Condition_C;
    end
  end

  // Supervisor / trap-enable bits and the window pointer. Trap entry saves
  // S into PS, enters supervisor, disables traps and rotates to a fresh window.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      psr_s  <= 1'b1;
      psr_ps <= 1'b0;
      psr_et <= 1'b1;
      cwp    <= 2'd0;
    end else if (do_psr) begin
      psr_s  <= Write_Data[7];
      psr_ps <= Write_Data[6];
      psr_et <= Write_Data[5];
      cwp    <= Write_Data[1:0];
    end else if (do_save) begin
      cwp <= cwp_dec;
    end else if (do_restore) begin
      cwp <= cwp_inc;
    end else if (state == TRAP_PSR) begin
      psr_ps <= psr_s;
      psr_s  <= 1'b1;
      psr_et <= 1'b0;
      cwp    <= cwp_dec;
    end
  end

  // WIM and TBA are written outside the request arbitration, but only while
  // no trap sequence is active.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      wim_bits <= 4'b0010;
      tba      <= 20'h00000;
    end else if (in_idle) begin
      if (Wim_Write) begin
        wim_bits <= Write_Data[3:0];
      end
      if (Tbr_Write) begin
        tba <= Write_Data[31:12];
      end
    end
  end

  // The trap type is captured when the trap starts and copied into TBR.tt
  // one cycle later; tt has no other write path.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      pending_tt <= 8'h00;
      tt         <= 8'h00;
    end else begin
      if (trap_start && psr_et) begin
        pending_tt <= start_tt;
      end
      if (state == TRAP_TBR) begin
        tt <= pending_tt;
      end
    end
  end

  // SPARC Bicc evaluation: Cond[2:0] picks the test, Cond[3] inverts it.
  always_comb begin
    case (Cond[2:0])
      3'd0:    base_taken = 1'b0;
      3'd1:    base_taken = icc_z;
      3'd2:    base_taken = icc_z | (icc_n ^ icc_v);
      3'd3:    base_taken = icc_n ^ icc_v;
      3'd4:    base_taken = icc_c | icc_z;
      3'd5:    base_taken = icc_c;
      3'd6:    base_taken = icc_n;
      default: base_taken = icc_v;
    endcase
    Branch_Taken = Cond[3] ? ~base_taken : base_taken;
  end

  assign PSR = {8'h00, icc_n, icc_z, icc_v, icc_c, 12'h000,
                psr_s, psr_ps, psr_et, 3'b000, cwp};
  assign WIM = {28'h0000000, wim_bits};
  assign TBR = {tba, tt, 4'h0};
  assign Carry_Out = icc_c;

endmodule

// File: tb/tb_processor_state_unit.sv
// ---------------------------------------------------------------------------
// tb_processor_state_unit
//
// Directed scenarios with fixed expected values, followed by a long run of
// random requests compared cycle by cycle against a behavioural model of
// the processor state (plain fields, a trap age counter and an error flag).
// ---------------------------------------------------------------------------
module tb_processor_state_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cond_n, cond_z, cond_v, cond_c;
  logic        cc_write, psr_write, wim_write, tbr_write;
  logic [31:0] write_data;
  logic        save, restore, trap_req;
  logic [7:0]  trap_type;
  logic [3:0]  cond;
  logic [31:0] psr, wim, tbr, trap_vector;
  logic        carry_out, branch_taken, busy, trap_valid, error_mode;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_n, m_z, m_v, m_c, m_s, m_ps, m_et;
  int          m_cwp;
  bit [3:0]    m_wim;
  bit [19:0]   m_tba;
  bit [7:0]    m_tt;
  bit [7:0]    m_pend;
  int          m_age;
  bit          m_err;

  processor_state_unit dut (
    .Clk          (clk),
    .Reset_N      (reset_n),
    .Condition_N  (cond_n),
    .Condition_Z  (cond_z),
    .Condition_V  (cond_v),
    .Condition_C  (cond_c),
    .Cc_Write     (cc_write),
    .Psr_Write    (psr_write),
    .Wim_Write    (wim_write),
    .Tbr_Write    (tbr_write),
    .Write_Data   (write_data),
    .Save         (save),
    .Restore      (restore),
    .Trap_Req     (trap_req),
    .Trap_Type    (trap_type),
    .Cond         (cond),
    .PSR          (psr),
    .WIM          (wim),
    .TBR          (tbr),
    .Carry_Out    (carry_out),
    .Branch_Taken (branch_taken),
    .Busy         (busy),
    .Trap_Valid   (trap_valid),
    .Trap_Vector  (trap_vector),
    .Error_Mode   (error_mode)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic bit branchRule(input logic [3:0] c, input bit n, input bit z,
                                    input bit v, input bit cy);
    bit base;
    case (c[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z;
      3'd2:    base = z | (n ^ v);
      3'd3:    base = n ^ v;
      3'd4:    base = cy | z;
      3'd5:    base = cy;
      3'd6:    base = n;
      default: base = v;
    endcase
    return c[3] ? !base : base;
  endfunction

  function automatic logic [31:0] modelPsr();
    return (32'(m_n) << 23) | (32'(m_z) << 22) | (32'(m_v) << 21) |
           (32'(m_c) << 20) | (32'(m_s) << 7) | (32'(m_ps) << 6) |
           (32'(m_et) << 5) | 32'(m_cwp);
  endfunction

  function automatic logic [31:0] modelTbr();
    return (32'(m_tba) << 12) | (32'(m_tt) << 4);
  endfunction

  function automatic void modelReset();
    {m_n, m_z, m_v, m_c} = 4'b0000;
    m_s = 1'b1; m_ps = 1'b0; m_et = 1'b1; m_cwp = 0;
    m_wim = 4'b0010; m_tba = '0; m_tt = '0; m_pend = '0;
    m_age = 0; m_err = 1'b0;
  endfunction

  // One rising edge of the model. m_age counts cycles since a trap started:
  // 1 writes tt, 2 updates PSR, 3 is the vector cycle.
  function automatic void modelEdge();
    bit       start;
    bit [7:0] code;
    if (m_err) return;
    if (m_age > 0) begin
      if (m_age == 1) m_tt = m_pend;
      if (m_age == 2) begin
        m_ps = m_s; m_s = 1'b1; m_et = 1'b0; m_cwp = (m_cwp + 3) % 4;
      end
      m_age = (m_age == 3) ? 0 : m_age + 1;
      return;
    end
    start = 1'b0;
    code  = 8'h00;
    if (trap_req) begin
      start = 1'b1; code = trap_type;
    end else if (save) begin
      if (m_wim[(m_cwp + 3) % 4]) begin start = 1'b1; code = 8'h05; end
      else m_cwp = (m_cwp + 3) % 4;
    end else if (restore) begin
      if (m_wim[(m_cwp + 1) % 4]) begin start = 1'b1; code = 8'h06; end
      else m_cwp = (m_cwp + 1) % 4;
    end else if (psr_write) begin
      {m_n, m_z, m_v, m_c} = write_data[23:20];
      m_s = write_data[7]; m_ps = write_data[6]; m_et = write_data[5];
      m_cwp = int'(write_data[1:0]);
    end else if (cc_write) begin
      {m_n, m_z, m_v, m_c} = {cond_n, cond_z, cond_v, cond_c};
    end
    if (wim_write) m_wim = write_data[3:0];
    if (tbr_write) m_tba = write_data[31:12];
    if (start) begin
      if (m_et) begin m_age = 1; m_pend = code; end
      else m_err = 1'b1;
    end
  endfunction

  task automatic compareAll();
    bit exp_valid;
    exp_valid = !m_err && (m_age == 3);
    checkOutput("psr", psr, modelPsr());
    checkOutput("wim", wim, 32'(m_wim));
    checkOutput("tbr", tbr, modelTbr());
    checkOutput("carry_out", 32'(carry_out), 32'(m_c));
    checkOutput("branch_taken", 32'(branch_taken),
                32'(branchRule(cond, m_n, m_z, m_v, m_c)));
    checkOutput("busy", 32'(busy), 32'(m_err || (m_age != 0)));
    checkOutput("trap_valid", 32'(trap_valid), 32'(exp_valid));
    checkOutput("trap_vector", trap_vector, exp_valid ? modelTbr() : 32'h0);
    checkOutput("error_mode", 32'(error_mode), 32'(m_err));
  endtask

  task automatic clearInputs();
    {cond_n, cond_z, cond_v, cond_c} = 4'b0000;
    {cc_write, psr_write, wim_write, tbr_write} = 4'b0000;
    {save, restore, trap_req} = 3'b000;
    write_data = '0;
    trap_type  = '0;
  endtask

  // Called just after a falling edge: inputs already set, step one rising
  // edge and compare on the following falling edge.
  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    compareAll();
  endtask

  // Short asynchronous reset pulse well away from the rising edge.
  task automatic pulseReset();
    reset_n = 1'b0;
    #1;
    modelReset();
    compareAll();
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic applyStimulus();
    cond_n     = 1'($urandom_range(1));
    cond_z     = 1'($urandom_range(1));
    cond_v     = 1'($urandom_range(1));
    cond_c     = 1'($urandom_range(1));
    cond       = 4'($urandom_range(15));
    trap_req   = ($urandom_range(15) == 0);
    trap_type  = 8'($urandom_range(255));
    save       = ($urandom_range(5) == 0);
    restore    = ($urandom_range(5) == 0);
    psr_write  = ($urandom_range(9) == 0);
    cc_write   = ($urandom_range(2) == 0);
    wim_write  = ($urandom_range(7) == 0);
    tbr_write  = ($urandom_range(7) == 0);
    write_data = $urandom;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_psr"}, psr, 32'h0000_00A0);
    checkOutput({tag, "_wim"}, wim, 32'h0000_0002);
    checkOutput({tag, "_tbr"}, tbr, 32'h0000_0000);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_valid"}, 32'(trap_valid), 32'h0);
    checkOutput({tag, "_vector"}, trap_vector, 32'h0);
    checkOutput({tag, "_error"}, 32'(error_mode), 32'h0);
  endtask

  initial begin
    clearInputs();
    cond    = 4'h0;
    reset_n = 1'b0;
    modelReset();
    @(negedge clk);
    checkResetValues("reset");
    compareAll();
    reset_n = 1'b1;

    // Flag latch and branch evaluation.
    cc_write = 1'b1;
    {cond_n, cond_z, cond_v, cond_c} = 4'b1011;
    cond = 4'h3;
    stepCycle();
    checkOutput("cc_psr", psr, 32'h00B0_00A0);
    checkOutput("cc_carry", 32'(carry_out), 32'h1);
    checkOutput("cc_cond3", 32'(branch_taken), 32'h0);
    clearInputs();
    cond = 4'hB;
    #1;
    checkOutput("cc_condB", 32'(branch_taken), 32'h1);

    // Window save then restore without a trap.
    pulseReset();
    save = 1'b1;
    stepCycle();
    checkOutput("save_psr", psr, 32'h0000_00A3);
    checkOutput("save_busy", 32'(busy), 32'h0);
    clearInputs();
    restore = 1'b1;
    stepCycle();
    checkOutput("restore_psr", psr, 32'h0000_00A0);
    clearInputs();

    // Window underflow trap and its vector timing.
    pulseReset();
    tbr_write  = 1'b1;
    write_data = 32'h4000_0000;
    stepCycle();
    clearInputs();
    restore = 1'b1;
    stepCycle();
    clearInputs();
    checkOutput("uf_busy0", 32'(busy), 32'h1);
    checkOutput("uf_valid0", 32'(trap_valid), 32'h0);
    stepCycle();
    checkOutput("uf_valid1", 32'(trap_valid), 32'h0);
    stepCycle();
    checkOutput("uf_valid2", 32'(trap_valid), 32'h1);
    checkOutput("uf_vector", trap_vector, 32'h4000_0060);
    checkOutput("uf_psr", psr, 32'h0000_00C3);
    stepCycle();
    checkOutput("uf_valid3", 32'(trap_valid), 32'h0);
    checkOutput("uf_busy3", 32'(busy), 32'h0);

    // Trap request wins over Save and Cc_Write in the same cycle.
    pulseReset();
    trap_req  = 1'b1;
    trap_type = 8'h02;
    save      = 1'b1;
    cc_write  = 1'b1;
    {cond_n, cond_z, cond_v, cond_c} = 4'b1111;
    stepCycle();
    clearInputs();
    checkOutput("prio_psr0", psr, 32'h0000_00A0);
    stepCycle();
    stepCycle();
    checkOutput("prio_valid", 32'(trap_valid), 32'h1);
    checkOutput("prio_tbr", tbr, 32'h0000_0020);
    checkOutput("prio_psr", psr, 32'h0000_00C3);
    stepCycle();

    // Second trap with ET=0 locks into error mode.
    trap_req  = 1'b1;
    trap_type = 8'h03;
    stepCycle();
    clearInputs();
    checkOutput("err_mode", 32'(error_mode), 32'h1);
    checkOutput("err_busy", 32'(busy), 32'h1);
    psr_write  = 1'b1;
    wim_write  = 1'b1;
    tbr_write  = 1'b1;
    write_data = 32'hFFFF_FFFF;
    repeat (4) stepCycle();
    clearInputs();
    checkOutput("err_busy_hold", 32'(busy), 32'h1);
    checkOutput("err_psr_hold", psr, 32'h0000_00C3);
    checkOutput("err_wim_hold", wim, 32'h0000_0002);
    checkOutput("err_tbr_hold", tbr, 32'h0000_0020);
    pulseReset();
    checkResetValues("err_reset");

    // Reset during TRAP_PSR aborts the trap.
    trap_req  = 1'b1;
    trap_type = 8'h09;
    stepCycle();
    clearInputs();
    stepCycle();
    checkOutput("abort_busy", 32'(busy), 32'h1);
    pulseReset();
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("abort_valid", 32'(trap_valid), 32'h0);
    end
    checkOutput("abort_psr", psr, 32'h0000_00A0);

    // Random traffic against the model, with occasional resets.
    pulseReset();
    for (int i = 0; i < 1500; i++) begin
      applyStimulus();
      if ($urandom_range(63) == 0) pulseReset();
      stepCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
